// File: rtl/pixel_pingpong_buffer_if.sv
// Pixel buffer bus: writer handshake, reader request, and the registered pixel/status outputs.
interface pixel_pingpong_buffer_if #(
  parameter int B = 6
) ();
  logic         write;
  logic [B-1:0] data_in;
  logic         write_ready;
  logic         read;
  logic [B-1:0] data_out;
  logic         data_valid;
  logic         underrun;
  logic         overrun;
  logic         clear_status;

  modport slave (
    input  write, data_in, read, clear_status,
    output write_ready, data_out, data_valid, underrun, overrun
  );

  modport master (
    output write, data_in, read, clear_status,
    input  write_ready, data_out, data_valid, underrun, overrun
  );
endinterface

// File: rtl/pixel_pingpong_buffer.sv
// Double-banked pixel buffer: writer fills the back bank, reader drains the front bank,
// banks swap when the front is empty and the back is full, with no lost cycle at the swap.
module pixel_pingpong_buffer #(
  parameter int A = 2,
  parameter int B = 6,
  parameter int P = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pixel_pingpong_buffer_if.slave io_bus
);

  localparam logic [A:0]   LEVEL_FULL = (A+1)'(P);
  localparam logic [A:0]   LEVEL_ZERO = (A+1)'(0);
  localparam logic [A-1:0] ADDR_LAST  = A'(P - 1);
  localparam logic [A-1:0] ADDR_ZERO  = A'(0);
  localparam int           DEPTH      = 2 ** A;

  logic [B-1:0] r_bank0 [DEPTH];
  logic [B-1:0] r_bank1 [DEPTH];

  logic         r_front_sel;
  logic [A-1:0] r_rd_addr;
  logic [A-1:0] r_wr_addr;
  logic [A:0]   r_front_level;
  logic         r_back_full;
  logic [B-1:0] r_data_out;
  logic         r_data_valid;
  logic         r_underrun;
  logic         r_overrun;

  logic         w_swap;
  logic         w_write_ready;
  logic         w_rd_bank;
  logic         w_wr_bank;
  logic [A-1:0] w_rd_addr_eff;
  logic [A:0]   w_level_eff;
  logic         w_rd_en;
  logic         w_wr_en;
  logic [B-1:0] w_rd_pixel;

  logic         w_front_sel_n;
  logic [A-1:0] w_rd_addr_n;
  logic [A-1:0] w_wr_addr_n;
  logic [A:0]   w_front_level_n;
  logic         w_back_full_n;
  logic [B-1:0] w_data_out_n;
  logic         w_data_valid_n;
  logic         w_underrun_n;
  logic         w_overrun_n;

  // Effective bank view for this cycle: a pending swap is applied before any read or write.
  always_comb begin
    w_swap        = (r_front_level == LEVEL_ZERO) && r_back_full;
    w_write_ready = !r_back_full || w_swap;
    w_rd_bank     = w_swap ? ~r_front_sel : r_front_sel;
    w_wr_bank     = ~w_rd_bank;
    w_rd_addr_eff = w_swap ? ADDR_ZERO : r_rd_addr;
    w_level_eff   = w_swap ? LEVEL_FULL : r_front_level;
    w_rd_en       = io_bus.read && (w_level_eff != LEVEL_ZERO);
    w_wr_en       = io_bus.write && w_write_ready;
    w_rd_pixel    = w_rd_bank ? r_bank1[w_rd_addr_eff] : r_bank0[w_rd_addr_eff];
  end

  // Next-state computation for pointers, level, bank flags, output pixel and sticky status.
  always_comb begin
    w_front_sel_n   = w_rd_bank;
    w_rd_addr_n     = w_rd_addr_eff;
    w_front_level_n = w_level_eff;
    w_data_out_n    = r_data_out;
    w_data_valid_n  = 1'b0;
    w_underrun_n    = io_bus.clear_status ? 1'b0 : r_underrun;
    w_overrun_n     = io_bus.clear_status ? 1'b0 : r_overrun;

    if (w_rd_en) begin
      w_rd_addr_n     = (w_rd_addr_eff == ADDR_LAST) ? ADDR_ZERO : w_rd_addr_eff + A'(1);
      w_front_level_n = w_level_eff - (A+1)'(1);
      w_data_out_n    = w_rd_pixel;
      w_data_valid_n  = 1'b1;
    end else if (io_bus.read) begin
      w_data_out_n    = {B{1'b0}};
      w_underrun_n    = 1'b1;
    end else begin
      w_data_valid_n  = 1'b0;
    end

    if (w_wr_en) begin
      w_wr_addr_n = (r_wr_addr == ADDR_LAST) ? ADDR_ZERO : r_wr_addr + A'(1);
    end else begin
      w_wr_addr_n = r_wr_addr;
    end

    // Completing a bank wins over the swap's clear: the swap cleared the old back, this fills the new one.
    if (w_wr_en && (r_wr_addr == ADDR_LAST)) begin
      w_back_full_n = 1'b1;
    end else if (w_swap) begin
      w_back_full_n = 1'b0;
    end else begin
      w_back_full_n = r_back_full;
    end

    if (io_bus.write && !w_write_ready) begin
      w_overrun_n = 1'b1;
    end else begin
      w_overrun_n = w_overrun_n;
    end
  end

  // Control and output registers; reset leaves bank storage untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_front_sel   <= 1'b0;
      r_rd_addr     <= ADDR_ZERO;
      r_wr_addr     <= ADDR_ZERO;
      r_front_level <= LEVEL_ZERO;
      r_back_full   <= 1'b0;
      r_data_out    <= {B{1'b0}};
      r_data_valid  <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_front_sel   <= w_front_sel_n;
      r_rd_addr     <= w_rd_addr_n;
      r_wr_addr     <= w_wr_addr_n;
      r_front_level <= w_front_level_n;
      r_back_full   <= w_back_full_n;
      r_data_out    <= w_data_out_n;
      r_data_valid  <= w_data_valid_n;
      r_underrun    <= w_underrun_n;
      r_overrun     <= w_overrun_n;
    end
  end

  // Pixel storage write port into the effective back bank.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_en) begin
      if (w_wr_bank) begin
        r_bank1[r_wr_addr] <= io_bus.data_in;
      end else begin
        r_bank0[r_wr_addr] <= io_bus.data_in;
      end
    end
  end

  assign io_bus.write_ready = w_write_ready;
  assign io_bus.data_out    = r_data_out;
  assign io_bus.data_valid  = r_data_valid;
  assign io_bus.underrun    = r_underrun;
  assign io_bus.overrun     = r_overrun;

endmodule

// File: tb/tb_pixel_pingpong_buffer.sv
// Self-checking bench for pixel_pingpong_buffer against a queue-based model of front/back banks.
module tb_pixel_pingpong_buffer;
  localparam int A = 2;
  localparam int B = 6;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pixel_pingpong_buffer_if #(.B(B)) bus_if ();

  pixel_pingpong_buffer #(.A(A), .B(B), .P(P)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a readable front queue and a filling back queue of at most P pixels.
  logic [B-1:0] m_front[$];
  logic [B-1:0] m_back[$];
  logic [B-1:0] m_dout;
  logic         m_valid, m_under, m_over;
  logic         exp_ready, obs_ready;

  task automatic model_reset();
    m_front.delete();
    m_back.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_under = 1'b0;
    m_over  = 1'b0;
  endtask

  task automatic apply_reset();
    bus_if.write = 1'b0; bus_if.data_in = '0; bus_if.read = 1'b0; bus_if.clear_status = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic wr, input logic [B-1:0] din, input logic rd, input logic clr);
    logic swap;
    bus_if.write = wr; bus_if.data_in = din; bus_if.read = rd; bus_if.clear_status = clr;
    #1;
    obs_ready = bus_if.write_ready;
    swap      = (m_front.size() == 0) && (m_back.size() == P);
    exp_ready = (m_back.size() < P) || swap;
    if (swap) begin
      m_front = m_back;
      m_back.delete();
    end
    if (clr) begin
      m_under = 1'b0;
      m_over  = 1'b0;
    end
    if (rd) begin
      if (m_front.size() > 0) begin
        m_dout  = m_front.pop_front();
        m_valid = 1'b1;
      end else begin
        m_dout  = '0;
        m_valid = 1'b0;
        m_under = 1'b1;
      end
    end else begin
      m_valid = 1'b0;
    end
    if (wr) begin
      if (exp_ready) m_back.push_back(din);
      else m_over = 1'b1;
    end
    @(posedge clk); #1;
    bus_if.write = 1'b0; bus_if.read = 1'b0; bus_if.clear_status = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if (bus_if.data_out !== 6'd0) $display("FAIL reset_data_out: got %0d want 0", bus_if.data_out); else n_pass++;
    n_checks++;
    if (bus_if.data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b want 0", bus_if.data_valid); else n_pass++;
    n_checks++;
    if (bus_if.write_ready !== 1'b1) $display("FAIL reset_write_ready: got %b want 1", bus_if.write_ready); else n_pass++;
    n_checks++;
    if ({bus_if.underrun, bus_if.overrun} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {bus_if.underrun, bus_if.overrun}); else n_pass++;
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 0; i < P; i++) begin
      cycle(1'b1, B'(i), 1'b0, 1'b0);
      n_checks++;
      if (obs_ready !== exp_ready) $display("FAIL fill_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); else n_pass++;
    end
    for (int i = 0; i <= P; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if ({bus_if.data_valid, bus_if.data_out, bus_if.underrun, bus_if.overrun} !== {m_valid, m_dout, m_under, m_over})
        $display("FAIL drain[%0d]: got v=%b d=%0d u=%b o=%b want v=%b d=%0d u=%b o=%b", i,
                 bus_if.data_valid, bus_if.data_out, bus_if.underrun, bus_if.overrun, m_valid, m_dout, m_under, m_over);
      else n_pass++;
    end
    n_checks++;
    if ({bus_if.data_valid, bus_if.underrun} !== 2'b01) $display("FAIL drain_underrun: got v=%b u=%b want v=0 u=1", bus_if.data_valid, bus_if.underrun); else n_pass++;
  endtask

  task automatic test_overfill();
    apply_reset();
    for (int i = 0; i <= 2 * P; i++) begin
      cycle(1'b1, B'(i), 1'b0, 1'b0);
      n_checks++;
      if (obs_ready !== exp_ready) $display("FAIL overfill_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); else n_pass++;
    end
    n_checks++;
    if ({obs_ready, bus_if.overrun} !== 2'b01) $display("FAIL overfill_drop: got ready=%b o=%b want ready=0 o=1", obs_ready, bus_if.overrun); else n_pass++;
    for (int i = 0; i < 2 * P; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if ({bus_if.data_valid, bus_if.data_out} !== {1'b1, B'(i)})
        $display("FAIL overfill_read[%0d]: got v=%b d=%0d want v=1 d=%0d", i, bus_if.data_valid, bus_if.data_out, i);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [B-1:0] d;
    apply_reset();
    for (int i = 0; i < P; i++) begin
      d = B'($urandom);
      cycle(1'b1, d, 1'b0, 1'b0);
    end
    for (int i = 0; i < 64; i++) begin
      d = B'($urandom);
      cycle(1'b1, d, 1'b1, 1'b0);
      n_checks++;
      if ({obs_ready, bus_if.data_valid, bus_if.data_out, bus_if.underrun, bus_if.overrun} !== {1'b1, 1'b1, m_dout, 1'b0, 1'b0})
        $display("FAIL stream[%0d]: got r=%b v=%b d=%0d u=%b o=%b want r=1 v=1 d=%0d u=0 o=0", i,
                 obs_ready, bus_if.data_valid, bus_if.data_out, bus_if.underrun, bus_if.overrun, m_dout);
      else n_pass++;
    end
  endtask

  task automatic test_clear_status();
    apply_reset();
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i <= 2 * P; i++) cycle(1'b1, B'($urandom), 1'b0, 1'b0);
    n_checks++;
    if ({bus_if.underrun, bus_if.overrun} !== 2'b11) $display("FAIL clear_setup: got %b want 11", {bus_if.underrun, bus_if.overrun}); else n_pass++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({bus_if.underrun, bus_if.overrun} !== 2'b00) $display("FAIL clear_alone: got %b want 00", {bus_if.underrun, bus_if.overrun}); else n_pass++;
    for (int i = 0; i < 2 * P; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if ({bus_if.data_valid, bus_if.underrun, bus_if.overrun} !== 3'b010)
      $display("FAIL clear_vs_underrun: got v=%b u=%b o=%b want v=0 u=1 o=0", bus_if.data_valid, bus_if.underrun, bus_if.overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    for (int i = 0; i < 2 * P; i++) cycle(1'b1, B'(i + 16), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if ({bus_if.data_valid, bus_if.data_out} !== {1'b1, 6'd17}) $display("FAIL middrain_pre: got v=%b d=%0d want v=1 d=17", bus_if.data_valid, bus_if.data_out); else n_pass++;
    apply_reset();
    #1;
    n_checks++;
    if (bus_if.write_ready !== 1'b1) $display("FAIL middrain_ready: got %b want 1", bus_if.write_ready); else n_pass++;
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if ({bus_if.data_valid, bus_if.data_out, bus_if.underrun} !== {1'b0, 6'd0, 1'b1})
      $display("FAIL middrain_read: got v=%b d=%0d u=%b want v=0 d=0 u=1", bus_if.data_valid, bus_if.data_out, bus_if.underrun);
    else n_pass++;
  endtask

  task automatic test_random();
    logic wr, rd, clr;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      wr  = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 19) == 0);
      cycle(wr, B'($urandom), rd, clr);
      n_checks++;
      if ({obs_ready, bus_if.data_valid, bus_if.data_out, bus_if.underrun, bus_if.overrun} !== {exp_ready, m_valid, m_dout, m_under, m_over})
        $display("FAIL random[%0d]: got r=%b v=%b d=%0d u=%b o=%b want r=%b v=%b d=%0d u=%b o=%b", i,
                 obs_ready, bus_if.data_valid, bus_if.data_out, bus_if.underrun, bus_if.overrun,
                 exp_ready, m_valid, m_dout, m_under, m_over);
      else n_pass++;
    end
  endtask

  initial begin
    bus_if.write = 1'b0; bus_if.data_in = '0; bus_if.read = 1'b0; bus_if.clear_status = 1'b0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_overfill();
    test_back_to_back();
    test_clear_status();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_pingpong_buffer.md
Name: pixel_pingpong_buffer

Overview:
- Synchronous double-banked (ping-pong) pixel buffer between the memory fetch side and the VGA pixel output path. It replaces the single-bank async-edge pixel buffer.
- The writer fills the back bank while the reader drains the front bank. Banks swap automatically when the front is empty and the back is full.
- Sticky underrun and overrun flags support debug of fetch timing.

Parameters:
- A, 2, address width per bank; requires 2^A >= P
- B, 6, bits per pixel
- P, 4, pixels per bank; P >= 2

Ports:
- Clock  input  1  system clock; all state changes on its rising edge
- Reset  input  1  synchronous, active-high reset
- Write  input  1  write request; DataIn is accepted when Write && WriteReady
- DataIn  input  B  pixel to store
- WriteReady  output  1  combinational; back bank can accept a pixel this cycle
- Read  input  1  read request, one pixel per cycle
- DataOut  output  B  registered pixel output
- DataValid  output  1  registered; DataOut carries a pixel read on the previous cycle
- Underrun  output  1  sticky; a Read found no data
- Overrun  output  1  sticky; a Write was dropped
- ClearStatus  input  1  clears Underrun and Overrun

Behaviour:
- Storage: two banks of P x B bits. The Front bank select bit names the read bank; the other bank is the back bank.
- State:
  - FrontSel (1 bit)
  - ReadAddress and WriteAddress (A bits each)
  - FrontLevel (A+1 bits; pixels remaining in front)
  - BackFull (1 bit)
- Reset (sync, priority over everything):
  - FrontSel=0, addresses=0, FrontLevel=0, BackFull=0
  - DataOut=0, DataValid=0, Underrun=0, Overrun=0
  - Bank contents are not cleared.
- SwapNow is combinational: FrontLevel==0 && BackFull.
  - On a SwapNow edge: FrontSel toggles, BackFull clears, ReadAddress clears, and FrontLevel loads P (before any same-cycle read decrement).
- Read, latency 1:
  - Read && (FrontLevel>0 || SwapNow): on the next edge, DataOut = pixel at ReadAddress of the effective front bank and DataValid=1. The effective front bank is the back bank when SwapNow is high.
  - The same edge advances ReadAddress (wraps P-1 -> 0) and decrements the effective FrontLevel. With SwapNow, FrontLevel becomes P-1.
  - Read with FrontLevel==0 && !BackFull: DataOut=0, DataValid=0, Underrun<=1.
  - No Read: DataValid=0 and DataOut holds its value.
- WriteReady = !BackFull || SwapNow.
- Write:
  - Write && WriteReady: DataIn is stored at WriteAddress of the effective back bank. With SwapNow, the effective back bank is the old front bank.
  - WriteAddress advances. At WriteAddress==P-1, WriteAddress wraps to 0 and BackFull<=1.
  - With SwapNow the write lands at WriteAddress, which is always 0 when BackFull is set.
  - Write && !WriteReady: data is dropped, Overrun<=1, and no state changes.
- Simultaneous Read and Write are always legal; they touch different banks, so there is no read/write collision.
- Status flags:
  - ClearStatus clears both flags.
  - A set event in the same cycle as ClearStatus wins (the flag ends at 1).
- Startup: the reader sees underrun until the first bank fills. There is no partial-bank read; a bank becomes readable only after P writes.
- Throughput: one write per cycle and one read per cycle are sustainable indefinitely with no lost cycle at the swap boundary.

Test Plan:
- Reset, then check reset values → DataOut=0, DataValid=0, WriteReady=1, Underrun=0, Overrun=0.
- Write 0,1,2,3 then read 4 cycles → DataOut 0,1,2,3 each one cycle after Read with DataValid=1. Fifth Read → DataValid=0 and Underrun=1.
- Write 8 pixels (0..7) with no reads.
  - Pixels 0..3 fill the back bank; WriteReady=1 at pixel 4 because of SwapNow, and pixels 4..7 fill the new back bank.
  - Ninth write → dropped, Overrun=1.
  - Reading 8 → 0..7 in order, with no DataValid gap at the pixel 3→4 boundary.
- Continuous Write and Read every cycle for 64 cycles after an initial fill of P → DataValid stays 1, output sequence equals input sequence, no flags.
- Pulse ClearStatus alone → both flags 0. Pulse ClearStatus on the same cycle as an underrun Read → Underrun stays 1.
- Reset asserted mid-drain with FrontLevel=2 and BackFull=1 → next cycle WriteReady=1, and a following Read gives DataValid=0 and Underrun=1 (no stale data).
